// File: rtl/music_box_pkg.sv
// music_box_pkg
// Shared definitions for the music box recording path: the recorder state
// encoding, the top-level mainState value that selects recording, and the
// SDRAM word-address width.
package music_box_pkg;

  localparam int         SDRAM_ADDR_W    = 25;
  localparam logic [4:0] MAIN_STATE_CODE = 5'd2;

  // IDLE must stay at zero: debugString reads all-zero while idle.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECORD = 3'd1,
    ST_DRAIN  = 3'd2,
    ST_DONE   = 3'd3,
    ST_FAIL   = 3'd4
  } rec_state_e;

endpackage

// File: rtl/sample_fifo.sv
// sample_fifo
// Synchronous FIFO holding captured audio samples until the SDRAM writer can
// take them. A push into a full FIFO is accepted only when a pop happens in
// the same cycle; otherwise it is ignored. A pop from an empty FIFO is ignored.
// Ports:
//   clock, reset      clock, asynchronous active-high reset
//   flush             synchronous clear of all contents
//   push, din         write request and data
//   pop, dout         read request; dout shows the head (valid when !empty)
//   full, empty       occupancy flags
module sample_fifo #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4   // power of two so the pointers wrap naturally
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign do_pop  = pop && !empty && !flush;
  assign do_push = push && (!full || do_pop) && !flush;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + (PTR_W+1)'(1);
      else if (do_pop && !do_push) count <= count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/music_box_state_record.sv
// music_box_state_record
// Records SAMPLE_COUNT audio samples into SDRAM while mainState selects the
// recording state. Samples are buffered in a small FIFO and written one
// command at a time using a valid/accepted handshake.
// Ports:
//   clock_50Mhz, reset             clock, asynchronous active-high reset
//   mainState                      top-level state; anything but MAIN_STATE_CODE aborts
//   sample_tick, audioInput        one-cycle sample strobe and its data
//   stateComplete, stateFailed     recording done / FIFO overflow
//   debugString                    {4'd0, state, writeAddr}
//   sdram_*                        write command interface (read side unused)
//
// state  | meaning
// IDLE   | waiting; entered whenever mainState is not the recording code
// RECORD | capturing samples and writing them out
// DRAIN  | all samples captured, emptying the FIFO
// DONE   | every sample written; stateComplete held
// FAIL   | FIFO overflowed; outstanding command finishes, no new ones
module music_box_state_record
  import music_box_pkg::*;
#(
  parameter logic [4:0] MAIN_STATE_CODE = music_box_pkg::MAIN_STATE_CODE,
  parameter int         SAMPLE_COUNT    = 220500,
  parameter int         FIFO_DEPTH      = 4
) (
  input  logic                    clock_50Mhz,
  input  logic                    reset,
  input  logic [4:0]              mainState,
  input  logic                    sample_tick,
  input  logic [15:0]             audioInput,
  output logic                    stateComplete,
  output logic                    stateFailed,
  output logic [31:0]             debugString,
  output logic [SDRAM_ADDR_W-1:0] sdram_inputAddress,
  output logic [15:0]             sdram_writeData,
  output logic                    sdram_isWriting,
  output logic                    sdram_inputValid,
  input  logic                    sdram_recievedCommand,
  input  logic                    sdram_isBusy,
  input  logic [15:0]             sdram_readData,
  input  logic                    sdram_outputValid
);

  localparam int CNT_W = $clog2(SAMPLE_COUNT + 1);

  rec_state_e              state;
  rec_state_e              state_nxt;
  logic [CNT_W-1:0]        sample_count;
  logic [SDRAM_ADDR_W-1:0] write_addr;
  logic [15:0]             fifo_head;
  logic                    fifo_full;
  logic                    fifo_empty;
  logic                    active;
  logic                    tick_push;
  logic                    issue;
  logic                    accept;
  logic                    overflow;
  logic                    last_sample;
  logic                    unused_read_side;

  assign unused_read_side = ^{sdram_readData, sdram_outputValid};

  assign active      = (mainState == MAIN_STATE_CODE);
  assign tick_push   = active && (state == ST_RECORD) && sample_tick;
  assign issue       = active && ((state == ST_RECORD) || (state == ST_DRAIN)) &&
                       !fifo_empty && !sdram_inputValid && !sdram_isBusy;
  assign accept      = sdram_inputValid && sdram_recievedCommand;
  // A pop in the same cycle frees the slot, so a full FIFO only overflows
  // when no write is being issued.
  assign overflow    = tick_push && fifo_full && !issue;
  assign last_sample = tick_push && (sample_count == CNT_W'(SAMPLE_COUNT - 1));

  assign debugString = {4'd0, state, write_addr};

  sample_fifo #(
    .WIDTH (16),
    .DEPTH (FIFO_DEPTH)
  ) u_sample_fifo (
    .clock (clock_50Mhz),
    .reset (reset),
    .flush (!active),
    .push  (tick_push),
    .pop   (issue),
    .din   (audioInput),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   state_nxt = ST_RECORD;
      ST_RECORD: begin
        if (overflow)         state_nxt = ST_FAIL;
        else if (last_sample) state_nxt = ST_DRAIN;
      end
      ST_DRAIN:  if (fifo_empty && !sdram_inputValid) state_nxt = ST_DONE;
      default:   state_nxt = state;
    endcase
    if (!active) state_nxt = ST_IDLE;
  end

  always_ff @(posedge clock_50Mhz or posedge reset) begin
    if (reset) begin
      state              <= ST_IDLE;
      sample_count       <= '0;
      write_addr         <= '0;
      stateComplete      <= 1'b0;
      stateFailed        <= 1'b0;
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
      sdram_isWriting    <= 1'b0;
      sdram_inputValid   <= 1'b0;
    end else if (!active) begin
      state              <= ST_IDLE;
      sample_count       <= '0;
      write_addr         <= '0;
      stateComplete      <= 1'b0;
      stateFailed        <= 1'b0;
      sdram_inputAddress <= '0;
      sdram_writeData    <= '0;
      sdram_isWriting    <= 1'b0;
      sdram_inputValid   <= 1'b0;
    end else begin
      state         <= state_nxt;
      stateComplete <= (state_nxt == ST_DONE);
      stateFailed   <= (state_nxt == ST_FAIL);
      if (tick_push && !overflow) sample_count <= sample_count + CNT_W'(1);
      // issue needs inputValid low and accept needs it high, so they never coincide
      if (issue) begin
        sdram_inputAddress <= write_addr;
        sdram_writeData    <= fifo_head;
        sdram_isWriting    <= 1'b1;
        sdram_inputValid   <= 1'b1;
      end else if (accept) begin
        sdram_isWriting  <= 1'b0;
        sdram_inputValid <= 1'b0;
        write_addr       <= write_addr + SDRAM_ADDR_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_music_box_state_record.sv
module tb_music_box_state_record;

  localparam int SC = 8;

  logic        clock_50Mhz = 1'b0;
  logic        reset;
  logic [4:0]  mainState;
  logic        sample_tick;
  logic [15:0] audioInput;
  logic        stateComplete;
  logic        stateFailed;
  logic [31:0] debugString;
  logic [24:0] sdram_inputAddress;
  logic [15:0] sdram_writeData;
  logic        sdram_isWriting;
  logic        sdram_inputValid;
  logic        sdram_recievedCommand = 1'b0;
  logic        sdram_isBusy;
  logic [15:0] sdram_readData;
  logic        sdram_outputValid;

  always #10 clock_50Mhz = ~clock_50Mhz;

  music_box_state_record #(
    .MAIN_STATE_CODE (5'd2),
    .SAMPLE_COUNT    (SC),
    .FIFO_DEPTH      (4)
  ) dut (
    .clock_50Mhz           (clock_50Mhz),
    .reset                 (reset),
    .mainState             (mainState),
    .sample_tick           (sample_tick),
    .audioInput            (audioInput),
    .stateComplete         (stateComplete),
    .stateFailed           (stateFailed),
    .debugString           (debugString),
    .sdram_inputAddress    (sdram_inputAddress),
    .sdram_writeData       (sdram_writeData),
    .sdram_isWriting       (sdram_isWriting),
    .sdram_inputValid      (sdram_inputValid),
    .sdram_recievedCommand (sdram_recievedCommand),
    .sdram_isBusy          (sdram_isBusy),
    .sdram_readData        (sdram_readData),
    .sdram_outputValid     (sdram_outputValid)
  );

  typedef struct packed {
    logic [24:0] addr;
    logic [15:0] data;
  } wr_t;

  wr_t  exp_q[$];
  wr_t  cur_exp;
  bit   cur_known = 1'b0;
  int   checks = 0;
  int   failures = 0;
  int   cmd_count = 0;
  int   next_addr = 0;
  int   dmin = 2;
  int   dmax = 2;
  int   wait_cnt = 0;
  int   cur_delay = 2;
  logic prev_valid = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_complete"}, 32'(stateComplete), 0);
    check({name, "_failed"},   32'(stateFailed), 0);
    check({name, "_debug"},    debugString, 0);
    check({name, "_addr"},     32'(sdram_inputAddress), 0);
    check({name, "_data"},     32'(sdram_writeData), 0);
    check({name, "_writing"},  32'(sdram_isWriting), 0);
    check({name, "_valid"},    32'(sdram_inputValid), 0);
  endtask

  // SDRAM controller model: accepts each command cur_delay cycles after it appears.
  always @(negedge clock_50Mhz) begin
    if (sdram_inputValid) begin
      sdram_recievedCommand = (wait_cnt == cur_delay);
      wait_cnt++;
    end else begin
      sdram_recievedCommand = 1'b0;
      wait_cnt  = 0;
      cur_delay = $urandom_range(dmax, dmin);
    end
  end

  // Monitor: every new command must be the oldest captured sample not yet
  // written, and must stay unchanged until the controller takes it.
  always @(negedge clock_50Mhz) begin
    if (sdram_inputValid) begin
      check("cmd_is_writing", 32'(sdram_isWriting), 1);
      if (!prev_valid) begin
        cmd_count++;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          cur_known = 1'b0;
          $display("FAIL unexpected_cmd actual=addr:%0h,data:%0h required=no_command",
                   sdram_inputAddress, sdram_writeData);
        end else begin
          cur_exp   = exp_q.pop_front();
          cur_known = 1'b1;
          check("cmd_addr", 32'(sdram_inputAddress), 32'(cur_exp.addr));
          check("cmd_data", 32'(sdram_writeData), 32'(cur_exp.data));
        end
      end else if (cur_known) begin
        check("hold_addr", 32'(sdram_inputAddress), 32'(cur_exp.addr));
        check("hold_data", 32'(sdram_writeData), 32'(cur_exp.data));
      end
    end
    prev_valid = sdram_inputValid;
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clock_50Mhz);
  endtask

  task automatic send_tick(input logic [15:0] d, input bit expect_wr);
    @(negedge clock_50Mhz);
    sample_tick = 1'b1;
    audioInput  = d;
    if (expect_wr) begin
      exp_q.push_back('{addr: 25'(next_addr), data: d});
      next_addr++;
    end
    @(negedge clock_50Mhz);
    sample_tick = 1'b0;
    audioInput  = 16'($urandom);
  endtask

  task automatic record_samples(input int n, input int gmin, input int gmax, input bit rnd);
    for (int i = 0; i < n; i++) begin
      logic [15:0] d;
      d = rnd ? 16'($urandom) : 16'(i + 1);
      send_tick(d, 1'b1);
      idle($urandom_range(gmax, gmin));
    end
  endtask

  task automatic restart(input string name);
    @(negedge clock_50Mhz);
    mainState = 5'd0;
    @(negedge clock_50Mhz);
    check_all_zero(name);
    exp_q.delete();
    next_addr = 0;
    mainState = 5'd2;
    idle(2);
  endtask

  task automatic wait_complete(input string name, input int base);
    int n;
    n = 0;
    while (!stateComplete && n < 600) begin
      @(negedge clock_50Mhz);
      n++;
    end
    if (!stateComplete) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=stateComplete:0 required=1", name);
    end else begin
      check({name, "_failed"},    32'(stateFailed), 0);
      check({name, "_writes"},    cmd_count - base, SC);
      check({name, "_q_empty"},   exp_q.size(), 0);
      check({name, "_dbg_state"}, 32'(debugString[27:25]), 3);
      check({name, "_dbg_addr"},  32'(debugString[24:0]), SC);
      idle(4);
      check({name, "_held"},      32'(stateComplete), 1);
    end
  endtask

  initial begin
    int base;
    int n;
    reset             = 1'b1;
    mainState         = 5'd0;
    sample_tick       = 1'b0;
    audioInput        = 16'd0;
    sdram_isBusy      = 1'b0;
    sdram_readData    = 16'd0;
    sdram_outputValid = 1'b0;
    idle(3);
    check_all_zero("in_reset");
    reset = 1'b0;
    idle(2);
    check_all_zero("after_reset");

    // Ordered capture 0x0001..0x0008, controller accepts after 2 cycles;
    // a late tick after capture ends must be ignored.
    dmin = 2; dmax = 2;
    restart("start_basic");
    base = cmd_count;
    record_samples(SC, 6, 8, 1'b0);
    send_tick(16'hBEEF, 1'b0);
    wait_complete("basic", base);

    // Randomized data, gaps and acceptance latency.
    for (int r = 0; r < 3; r++) begin
      dmin = 0; dmax = 4;
      restart("start_rand");
      base = cmd_count;
      record_samples(SC, 8, 12, 1'b1);
      wait_complete("rand", base);
    end

    // Controller withholds acceptance for 10 cycles per command.
    dmin = 10; dmax = 10;
    restart("start_slow");
    base = cmd_count;
    record_samples(SC, 14, 16, 1'b1);
    wait_complete("slow", base);

    // Controller busy across 5 ticks: the 5th overflows the FIFO.
    dmin = 1; dmax = 1;
    restart("start_busy");
    base = cmd_count;
    sdram_isBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_tick(16'($urandom), 1'b0);
      idle(1);
    end
    check("busy_no_fail_at_4", 32'(stateFailed), 0);
    send_tick(16'($urandom), 1'b0);
    check("busy_fail_at_5", 32'(stateFailed), 1);
    check("busy_fail_dbg_state", 32'(debugString[27:25]), 4);
    sdram_isBusy = 1'b0;
    idle(20);
    check("busy_no_cmd_after_fail", cmd_count - base, 0);
    check("busy_fail_held", 32'(stateFailed), 1);

    // Leave the recording state mid-capture, then start over from address 0.
    dmin = 4; dmax = 4;
    restart("start_abort");
    record_samples(3, 2, 2, 1'b1);
    mainState = 5'd0;
    @(negedge clock_50Mhz);
    check_all_zero("abort");
    exp_q.delete();
    next_addr = 0;
    mainState = 5'd2;
    idle(2);
    dmin = 0; dmax = 3;
    base = cmd_count;
    record_samples(SC, 8, 10, 1'b1);
    wait_complete("after_abort", base);

    // Reset while a command is outstanding.
    dmin = 10; dmax = 10;
    restart("start_rst");
    send_tick(16'h1234, 1'b1);
    n = 0;
    while (!sdram_inputValid && n < 20) begin
      @(negedge clock_50Mhz);
      n++;
    end
    check("rst_cmd_pending", 32'(sdram_inputValid), 1);
    #2 reset = 1'b1;
    #1 check_all_zero("rst_async");
    exp_q.delete();
    next_addr = 0;
    @(negedge clock_50Mhz);
    reset = 1'b0;
    #1 check("rst_release_idle", 32'(debugString[27:25]), 0);
    base = cmd_count;
    idle(12);
    check("rst_no_reissue", cmd_count - base, 0);

    // FIFO full, then a tick lands in the same cycle as a pop.
    dmin = 1; dmax = 1;
    restart("start_full");
    base = cmd_count;
    sdram_isBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      send_tick(16'(16'h0A00 + i), 1'b1);
      idle(1);
    end
    check("full_no_fail", 32'(stateFailed), 0);
    check("full_no_cmd_while_busy", cmd_count - base, 0);
    @(negedge clock_50Mhz);
    sdram_isBusy = 1'b0;
    sample_tick  = 1'b1;
    audioInput   = 16'h0A04;
    exp_q.push_back('{addr: 25'(next_addr), data: 16'h0A04});
    next_addr++;
    @(negedge clock_50Mhz);
    sample_tick = 1'b0;
    check("full_push_pop_no_fail", 32'(stateFailed), 0);
    idle(12);
    for (int i = 5; i < SC; i++) begin
      send_tick(16'(16'h0A00 + i), 1'b1);
      idle(12);
    end
    wait_complete("full", base);

    mainState = 5'd0;
    idle(2);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/music_box_state_record.md
MUSIC_BOX_STATE_RECORD -- requirements
Module: music_box_state_record

Interface
REQ-001 Parameters SHALL be:
  - MAIN_STATE_CODE, 5'd2, mainState value that activates recording.
  - SAMPLE_COUNT, 220500, samples per recording (10 s at 22050 Hz).
  - FIFO_DEPTH, 4, sample buffer depth (power of two).
REQ-002 Ports SHALL be:
  - clock_50Mhz  in  1  sole clock.
  - reset  in  1  asynchronous, active-high reset.
  - mainState  in  5  top-level state from the state controller.
  - sample_tick  in  1  one-cycle 22050 Hz strobe, synchronous to clock_50Mhz.
  - audioInput  in  16  microphone/ADC sample, valid when sample_tick=1.
  - stateComplete  out  1  recording finished successfully.
  - stateFailed  out  1  FIFO overflow occurred.
  - debugString  out  32  {4'd0, state[2:0], writeAddr[24:0]}.
  - sdram_inputAddress  out  25  write address.
  - sdram_writeData  out  16  write data.
  - sdram_isWriting  out  1  1 = write command.
  - sdram_inputValid  out  1  command request.
  - sdram_recievedCommand  in  1  controller accepted the command.
  - sdram_isBusy  in  1  controller cannot take a new command.
  - sdram_readData  in  16  unused.
  - sdram_outputValid  in  1  unused.

Function
REQ-003 States SHALL be IDLE, RECORD, DRAIN, DONE and FAIL.
REQ-004 Whenever mainState != MAIN_STATE_CODE, the next clock SHALL:
  - go to IDLE;
  - flush the FIFO;
  - clear sampleCount and writeAddr;
  - drive all outputs to 0.
REQ-005 IDLE SHALL go to RECORD on the first clock with mainState == MAIN_STATE_CODE.
REQ-006 In RECORD, each sample_tick SHALL push audioInput into the FIFO and increment sampleCount.
REQ-007 When sampleCount reaches SAMPLE_COUNT, the block SHALL go to DRAIN; sample_tick SHALL be ignored in DRAIN, DONE and FAIL.
REQ-008 A push into a full FIFO without a simultaneous pop SHALL drop the sample and go to FAIL.
REQ-009 A push and a pop in the same cycle with the FIFO full SHALL be accepted without overflow.
REQ-010 A write SHALL be issued when all of the following hold: state is RECORD or DRAIN, FIFO non-empty, sdram_inputValid=0, sdram_isBusy=0. Issuing a write SHALL:
  - pop the FIFO head;
  - drive sdram_inputAddress={writeAddr}, sdram_writeData=head, sdram_isWriting=1, sdram_inputValid=1 on the next edge.
REQ-011 Address, data and sdram_inputValid SHALL be held stable until sdram_recievedCommand is sampled high.
REQ-012 On the cycle after acceptance, the block SHALL drop sdram_inputValid and increment writeAddr; consecutive commands are therefore separated by at least one idle cycle.
REQ-013 writeAddr SHALL start at 0 and run 0..SAMPLE_COUNT-1; samples SHALL be written in capture order.
REQ-014 DRAIN SHALL go to DONE when the FIFO is empty and no command is outstanding.
REQ-015 DONE SHALL assert stateComplete=1 and hold it until mainState changes.
REQ-016 FAIL SHALL assert stateFailed=1, complete any outstanding command, issue no new commands, and hold until mainState changes.
REQ-017 sdram_isWriting SHALL be 1 whenever sdram_inputValid=1.

Reset
REQ-018 Asserting reset SHALL immediately:
  - force state IDLE;
  - empty the FIFO;
  - clear all counters;
  - set every output to 0.
REQ-019 Reset asserted mid-command SHALL drop sdram_inputValid asynchronously; no command SHALL be reissued after release.

Structure
REQ-020 The state enum, MAIN_STATE_CODE and the SDRAM address width (25) SHALL live in the shared package music_box_pkg.
REQ-021 The buffer SHALL be the sub-module sample_fifo: synchronous, parameterised width and depth, with full/empty flags and simultaneous push/pop support.

Verification
REQ-022 Run with SAMPLE_COUNT=8. mainState=2, 8 ticks with data 0x0001..0x0008, controller accepts after 2 cycles -> writes to addresses 0..7 with matching data in order, then stateComplete=1.
REQ-023 Hold sdram_isBusy=1 across 5 ticks -> stateFailed=1 on the 5th tick, and no command is issued after FAIL.
REQ-024 Withhold sdram_recievedCommand for 10 cycles -> address and data stay stable and sdram_inputValid stays 1 throughout.
REQ-025 Change mainState to 0 mid-recording -> all outputs are 0 the next cycle; returning to 2 restarts at address 0.
REQ-026 Assert reset during an outstanding command -> sdram_inputValid is 0 immediately, and state is IDLE after release.
REQ-027 FIFO full, with sample_tick and acceptance in the same cycle -> no FAIL, and all samples are written.
